// File: rtl/or_event_agg_pkg.sv
// ----------------------------------------------------------------------------
// or_event_agg_pkg
// Shared constants for the event aggregator: capture-mode encodings, the
// legal channel-count range, and a helper that returns the index width a
// given channel count needs.
// No ports (package).
// ----------------------------------------------------------------------------
package or_event_agg_pkg;

    // Capture-mode encodings used for the MODE parameter.
    localparam int MODE_LEVEL = 0;
    localparam int MODE_EDGE  = 1;

    typedef enum logic {
        CAP_LEVEL = 1'b0,
        CAP_EDGE  = 1'b1
    } cap_mode_e;

    // Legal channel-count range.
    localparam int N_MIN = 2;
    localparam int N_MAX = 32;

    // Index width needed to name one of n channels.
    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/or_tree_n.sv
// ----------------------------------------------------------------------------
// or_tree_n
// Parametrised N-input combinational OR reduction.
// Ports:
//   in_vec  [N-1:0]  input vector to reduce
//   or_out           1 when any bit of in_vec is 1
// ----------------------------------------------------------------------------
module or_tree_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] in_vec,
    output logic         or_out
);

    assign or_out = |in_vec;

endmodule

// File: rtl/or_event_agg.sv
// ----------------------------------------------------------------------------
// or_event_agg
// Sticky event aggregator. Each channel latches an event (level or rising
// edge, selected by MODE) into a pending bit that stays set until a
// write-1-to-clear. The masked pending bits are OR-reduced into a registered
// interrupt-style output, and a registered lowest-index encoder names the
// highest-priority (lowest-numbered) active channel.
// Ports:
//   clk        clock, all state updates on its rising edge
//   rst        asynchronous active-high reset
//   in   [N]   raw event lines
//   mask [N]   per-channel enable for out/idx (does not gate capture)
//   clr  [N]   write-1-to-clear for pending bits
//   pending[N] sticky captured-event register
//   out        registered OR of (pending & mask)
//   idx  [IW]  registered lowest channel with pending & mask set
//   idx_valid  registered; 1 when idx is meaningful (equals out)
// ----------------------------------------------------------------------------
module or_event_agg
    import or_event_agg_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = MODE_LEVEL,
    parameter int IW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in,
    input  logic [N-1:0]  mask,
    input  logic [N-1:0]  clr,
    output logic [N-1:0]  pending,
    output logic          out,
    output logic [IW-1:0] idx,
    output logic          idx_valid
);

    localparam cap_mode_e CAP_MODE = (MODE == MODE_EDGE) ? CAP_EDGE : CAP_LEVEL;

    generate
        if (N < N_MIN || N > N_MAX || IW != idx_width(N) ||
            (MODE != MODE_LEVEL && MODE != MODE_EDGE)) begin : g_bad_param
            $error("or_event_agg: illegal parameter combination");
        end
    endgenerate

    logic [N-1:0]  prev_q, prev_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  capture;
    logic [N-1:0]  hit;
    logic          out_q, out_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          idx_valid_q, idx_valid_d;

    // Capture and sticky pending update. Set has priority over clear, so an
    // event arriving in the same cycle as its clear is never lost.
    always_comb begin
        prev_d = in;
        if (CAP_MODE == CAP_EDGE) begin
            capture = in & ~prev_q;
        end else begin
            capture = in;
        end
        pending_d = capture | (pending_q & ~clr);
    end

    // Outputs are derived from the registered pending bits, so they trail
    // pending by one edge and have no combinational path from in.
    assign hit = pending_q & mask;

    or_tree_n #(
        .N(N)
    ) u_or_tree (
        .in_vec (hit),
        .or_out (out_d)
    );

    // Lowest-index priority encoder: scanning downward lets the lowest set
    // bit overwrite any higher one.
    always_comb begin
        idx_d       = '0;
        idx_valid_d = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx_d       = IW'(i);
                idx_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= '0;
            pending_q   <= '0;
            out_q       <= 1'b0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            pending_q   <= pending_d;
            out_q       <= out_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
        end
    end

    assign pending   = pending_q;
    assign out       = out_q;
    assign idx       = idx_q;
    assign idx_valid = idx_valid_q;

endmodule

// File: tb/tb_or_event_agg.sv
// ----------------------------------------------------------------------------
// tb_or_event_agg
// Directed checks on two N=4 instances (level and edge capture) plus a
// randomised sweep of N=2/7/32 instances against a cycle-level model.
// ----------------------------------------------------------------------------
module tb_or_event_agg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // ---------------- directed DUTs (N=4) ----------------
    logic [3:0] in0, mask0, clr0, pend0;
    logic       out0, val0;
    logic [1:0] idx0;

    logic [3:0] in1, mask1, clr1, pend1;
    logic       out1, val1;
    logic [1:0] idx1;

    or_event_agg #(.N(4), .MODE(0), .IW(2)) u_lvl (
        .clk(clk), .rst(rst), .in(in0), .mask(mask0), .clr(clr0),
        .pending(pend0), .out(out0), .idx(idx0), .idx_valid(val0)
    );

    or_event_agg #(.N(4), .MODE(1), .IW(2)) u_edg (
        .clk(clk), .rst(rst), .in(in1), .mask(mask1), .clr(clr1),
        .pending(pend1), .out(out1), .idx(idx1), .idx_valid(val1)
    );

    // ---------------- sweep DUTs ----------------
    logic [31:0] sw_in   [3];
    logic [31:0] sw_mask [3];
    logic [31:0] sw_clr  [3];

    logic [1:0]  s2_pend;  logic s2_out;  logic [0:0] s2_idx;  logic s2_val;
    logic [6:0]  s7_pend;  logic s7_out;  logic [2:0] s7_idx;  logic s7_val;
    logic [31:0] s32_pend; logic s32_out; logic [4:0] s32_idx; logic s32_val;

    or_event_agg #(.N(2), .MODE(1), .IW(1)) u_s2 (
        .clk(clk), .rst(rst), .in(sw_in[0][1:0]), .mask(sw_mask[0][1:0]),
        .clr(sw_clr[0][1:0]), .pending(s2_pend), .out(s2_out),
        .idx(s2_idx), .idx_valid(s2_val)
    );

    or_event_agg #(.N(7), .MODE(0), .IW(3)) u_s7 (
        .clk(clk), .rst(rst), .in(sw_in[1][6:0]), .mask(sw_mask[1][6:0]),
        .clr(sw_clr[1][6:0]), .pending(s7_pend), .out(s7_out),
        .idx(s7_idx), .idx_valid(s7_val)
    );

    or_event_agg #(.N(32), .MODE(1), .IW(5)) u_s32 (
        .clk(clk), .rst(rst), .in(sw_in[2]), .mask(sw_mask[2]),
        .clr(sw_clr[2]), .pending(s32_pend), .out(s32_out),
        .idx(s32_idx), .idx_valid(s32_val)
    );

    // Reference model state for the sweep instances.
    logic [31:0] m_prev [3];
    logic [31:0] m_pend [3];
    logic        m_out  [3];
    int          m_idx  [3];

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lvl(input string t, input logic [3:0] p, input logic o,
                           input logic [1:0] i, input logic v);
        chk_eq({t, "_lvl_pend"}, pend0, p);
        chk_eq({t, "_lvl_out"},  out0,  o);
        chk_eq({t, "_lvl_idx"},  idx0,  i);
        chk_eq({t, "_lvl_val"},  val0,  v);
    endtask

    task automatic chk_edg(input string t, input logic [3:0] p, input logic o,
                           input logic [1:0] i, input logic v);
        chk_eq({t, "_edg_pend"}, pend1, p);
        chk_eq({t, "_edg_out"},  out1,  o);
        chk_eq({t, "_edg_idx"},  idx1,  i);
        chk_eq({t, "_edg_val"},  val1,  v);
    endtask

    // Advance model k by one clock edge using the inputs currently applied.
    task automatic model_step(input int k, input bit edge_mode);
        logic [31:0] hit;
        logic [31:0] cap;
        hit = m_pend[k] & sw_mask[k];
        cap = edge_mode ? (sw_in[k] & ~m_prev[k]) : sw_in[k];
        m_pend[k] = cap | (m_pend[k] & ~sw_clr[k]);
        m_prev[k] = sw_in[k];
        m_out[k]  = |hit;
        m_idx[k]  = 0;
        for (int b = 31; b >= 0; b--) begin
            if (hit[b]) m_idx[k] = b;
        end
    endtask

    initial begin
        in0 = '0; mask0 = '0; clr0 = '0;
        in1 = '0; mask1 = '0; clr1 = '0;
        for (int k = 0; k < 3; k++) begin
            sw_in[k] = '0; sw_mask[k] = '0; sw_clr[k] = '0;
            m_prev[k] = '0; m_pend[k] = '0; m_out[k] = 1'b0; m_idx[k] = 0;
        end

        // Reset state before any clock edge.
        #2;
        chk_lvl("rst0", 4'b0000, 1'b0, 2'd0, 1'b0);
        chk_edg("rst0", 4'b0000, 1'b0, 2'd0, 1'b0);
        step();
        step();
        rst = 1'b0;
        mask0 = 4'b1111;
        mask1 = 4'b1111;

        // Level capture, hold, then clear.
        in0 = 4'b0100; step(); chk_lvl("lvl_cap", 4'b0100, 1'b0, 2'd0, 1'b0);
        in0 = 4'b0000; step(); chk_lvl("lvl_out", 4'b0100, 1'b1, 2'd2, 1'b1);
        step();                chk_lvl("lvl_hold", 4'b0100, 1'b1, 2'd2, 1'b1);
        clr0 = 4'b0100; step(); chk_lvl("lvl_clr", 4'b0000, 1'b1, 2'd2, 1'b1);
        clr0 = 4'b0000; step(); chk_lvl("lvl_idle", 4'b0000, 1'b0, 2'd0, 1'b0);

        // Set/clear collision: set wins.
        in0 = 4'b0010; step(); chk_lvl("col_cap", 4'b0010, 1'b0, 2'd0, 1'b0);
        in0 = 4'b0000; step(); chk_lvl("col_pre", 4'b0010, 1'b1, 2'd1, 1'b1);
        in0 = 4'b0010; clr0 = 4'b0010; step(); chk_lvl("col_hit", 4'b0010, 1'b1, 2'd1, 1'b1);
        in0 = 4'b0000; clr0 = 4'b0000; step(); chk_lvl("col_post", 4'b0010, 1'b1, 2'd1, 1'b1);
        clr0 = 4'b0010; step(); chk_lvl("col_clr", 4'b0000, 1'b1, 2'd1, 1'b1);
        clr0 = 4'b0000; step(); chk_lvl("col_idle", 4'b0000, 1'b0, 2'd0, 1'b0);

        // All channels at once: idx is 0.
        in0 = 4'b1111; step(); chk_lvl("all_cap", 4'b1111, 1'b0, 2'd0, 1'b0);
        in0 = 4'b0000; step(); chk_lvl("all_out", 4'b1111, 1'b1, 2'd0, 1'b1);
        clr0 = 4'b1111; step(); chk_lvl("all_clr", 4'b0000, 1'b1, 2'd0, 1'b1);
        clr0 = 4'b0000; step(); chk_lvl("all_idle", 4'b0000, 1'b0, 2'd0, 1'b0);

        // Masking and priority, then clearing the lowest moves idx.
        mask0 = 4'b1100; in0 = 4'b0101; step(); chk_lvl("msk_cap", 4'b0101, 1'b0, 2'd0, 1'b0);
        in0 = 4'b0000; step(); chk_lvl("msk_out", 4'b0101, 1'b1, 2'd2, 1'b1);
        mask0 = 4'b0000; step(); chk_lvl("msk_off", 4'b0101, 1'b0, 2'd0, 1'b0);
        mask0 = 4'b1111; step(); chk_lvl("msk_on", 4'b0101, 1'b1, 2'd0, 1'b1);
        clr0 = 4'b0001; step(); chk_lvl("pri_clr", 4'b0100, 1'b1, 2'd0, 1'b1);
        clr0 = 4'b0000; step(); chk_lvl("pri_next", 4'b0100, 1'b1, 2'd2, 1'b1);
        clr0 = 4'b1111; step(); chk_lvl("pri_clr2", 4'b0000, 1'b1, 2'd2, 1'b1);
        clr0 = 4'b0000; step(); chk_lvl("pri_idle", 4'b0000, 1'b0, 2'd0, 1'b0);

        // Edge mode: held input captures once; after clear it stays clear.
        in1 = 4'b0001; step(); chk_edg("edg_cap", 4'b0001, 1'b0, 2'd0, 1'b0);
        step();                chk_edg("edg_hold", 4'b0001, 1'b1, 2'd0, 1'b1);
        clr1 = 4'b0001; step(); chk_edg("edg_clr", 4'b0000, 1'b1, 2'd0, 1'b1);
        clr1 = 4'b0000; step(); chk_edg("edg_hi1", 4'b0000, 1'b0, 2'd0, 1'b0);
        step();                chk_edg("edg_hi2", 4'b0000, 1'b0, 2'd0, 1'b0);
        in1 = 4'b0000; step(); chk_edg("edg_fall", 4'b0000, 1'b0, 2'd0, 1'b0);
        in1 = 4'b0001; step(); chk_edg("edg_rise", 4'b0001, 1'b0, 2'd0, 1'b0);
        in1 = 4'b0000; step(); chk_edg("edg_out", 4'b0001, 1'b1, 2'd0, 1'b1);
        clr1 = 4'b0001; step();
        clr1 = 4'b0000; step(); chk_edg("edg_idle", 4'b0000, 1'b0, 2'd0, 1'b0);

        // Asynchronous reset mid-cycle discards everything.
        in0 = 4'b1111; step(); chk_lvl("ar_cap", 4'b1111, 1'b0, 2'd0, 1'b0);
        in0 = 4'b0000; in1 = 4'b1000; step();
        chk_lvl("ar_pre", 4'b1111, 1'b1, 2'd0, 1'b1);
        chk_edg("ar_pre", 4'b1000, 1'b0, 2'd0, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk_lvl("ar_async", 4'b0000, 1'b0, 2'd0, 1'b0);
        chk_edg("ar_async", 4'b0000, 1'b0, 2'd0, 1'b0);
        #2 rst = 1'b0;
        step();
        chk_lvl("ar_rel", 4'b0000, 1'b0, 2'd0, 1'b0);
        chk_edg("ar_rel", 4'b1000, 1'b0, 2'd0, 1'b0);
        step();
        chk_lvl("ar_rel2", 4'b0000, 1'b0, 2'd0, 1'b0);
        chk_edg("ar_rel2", 4'b1000, 1'b1, 2'd3, 1'b1);
        in1 = 4'b0000;

        // Width sweep against the reference model.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 250; c++) begin
            for (int k = 0; k < 3; k++) begin
                logic [31:0] wm;
                wm = (k == 0) ? 32'h3 : ((k == 1) ? 32'h7F : 32'hFFFF_FFFF);
                sw_in[k]   = $urandom & wm;
                sw_clr[k]  = $urandom & $urandom & wm;
                sw_mask[k] = ($urandom_range(0, 3) == 0) ? wm : ($urandom & wm);
            end
            model_step(0, 1'b1);
            model_step(1, 1'b0);
            model_step(2, 1'b1);
            step();
            chk_eq("s2_pend", s2_pend, m_pend[0]);
            chk_eq("s2_out",  s2_out,  m_out[0]);
            chk_eq("s2_idx",  s2_idx,  m_idx[0]);
            chk_eq("s2_val",  s2_val,  m_out[0]);
            chk_eq("s2_rng",  (int'(s2_idx) < 2), 1'b1);
            chk_eq("s7_pend", s7_pend, m_pend[1]);
            chk_eq("s7_out",  s7_out,  m_out[1]);
            chk_eq("s7_idx",  s7_idx,  m_idx[1]);
            chk_eq("s7_val",  s7_val,  m_out[1]);
            chk_eq("s7_rng",  (int'(s7_idx) < 7), 1'b1);
            chk_eq("s32_pend", s32_pend, m_pend[2]);
            chk_eq("s32_out",  s32_out,  m_out[2]);
            chk_eq("s32_idx",  s32_idx,  m_idx[2]);
            chk_eq("s32_val",  s32_val,  m_out[2]);
            chk_eq("s32_rng",  (int'(s32_idx) < 32), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
